// File: rtl/cnn_image_loader_if.sv
// cnn_image_loader_if: pixel beat stream, core handshake and image bus between feeder, loader and CNN core.
interface cnn_image_loader_if #(
   parameter int IMAGE_WIDTH     = 28,
   parameter int IMAGE_HEIGHT    = 28,
   parameter int PIXELS_PER_BEAT = 8
);
   logic [PIXELS_PER_BEAT-1:0]               pix_data;
   logic                                     pix_sof;
   logic                                     pix_valid;
   logic                                     pix_ready;
   logic                                     cnn_done;
   logic [IMAGE_HEIGHT-1:0][IMAGE_WIDTH-1:0] image_input;
   logic                                     convolution_enable;
   logic                                     loader_busy;
   logic                                     frame_error;
   modport master (
      output pix_data, pix_sof, pix_valid, cnn_done,
      input  pix_ready, image_input, convolution_enable, loader_busy, frame_error
   );
   modport slave (
      input  pix_data, pix_sof, pix_valid, cnn_done,
      output pix_ready, image_input, convolution_enable, loader_busy, frame_error
   );
endinterface

// File: rtl/cnn_image_loader.sv
// cnn_image_loader: packs a beat stream into the CNN image array and pulses the core's active-low start.
// Optional LOADER_CHECKSUM_EN: trailing XOR beat checked in a CHECK state, mismatch sets sticky frame_error.
module cnn_image_loader #(
   parameter int IMAGE_WIDTH     = 28,
   parameter int IMAGE_HEIGHT    = 28,
   parameter int PIXELS_PER_BEAT = 8
) (
   input logic               clk,
   input logic               rst_cnn,
   cnn_image_loader_if.slave bus
);
   localparam int NUM_BEATS = IMAGE_WIDTH*IMAGE_HEIGHT/PIXELS_PER_BEAT;
   localparam int RW = $clog2(IMAGE_HEIGHT+1);
   localparam int CW = $clog2(IMAGE_WIDTH+PIXELS_PER_BEAT);
   localparam int RI = $clog2(IMAGE_HEIGHT);
   localparam int CI = $clog2(IMAGE_WIDTH);
   localparam int BW = $clog2(NUM_BEATS+2);
   localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, START = 3'd2, BUSY = 3'd3, CHECK = 3'd4;
   logic [2:0] state, nxt;
   logic [BW-1:0] beat_cnt;
   logic [RW-1:0] row, base_r;
   logic [CW-1:0] col, base_c;
   logic [RW-1:0] pr [PIXELS_PER_BEAT+1];
   logic [CW-1:0] pc [PIXELS_PER_BEAT+1];
   logic [CW-1:0] cs [PIXELS_PER_BEAT+1];
   logic [IMAGE_HEIGHT-1:0][IMAGE_WIDTH-1:0] img;
   logic rdy_en, conv_en, accept, sof_acc, write, last, data_beat, csum_ok;
`ifdef LOADER_CHECKSUM_EN
   localparam int LAST_CNT = NUM_BEATS;
   logic [PIXELS_PER_BEAT-1:0] csum;
   logic ok_q, err;
   assign data_beat = beat_cnt != BW'(NUM_BEATS);
   assign csum_ok   = ok_q;
   assign bus.frame_error = err;
   always_ff @(posedge clk or negedge rst_cnn)
      if (!rst_cnn) begin
         csum <= '0;
         ok_q <= 1'b0;
         err  <= 1'b0;
      end else begin
         if (sof_acc) csum <= bus.pix_data;
         else if (write) csum <= csum ^ bus.pix_data;
         if (last) ok_q <= bus.pix_data == csum;
         if (sof_acc) err <= 1'b0;
         else if (state == CHECK && !ok_q) err <= 1'b1;
      end
`else
   localparam int LAST_CNT = NUM_BEATS-1;
   assign data_beat = 1'b1;
   assign csum_ok   = 1'b1;
   assign bus.frame_error = 1'b0;
`endif
   // ready only after the first clock following reset release
   assign bus.pix_ready          = rdy_en & (state == IDLE | state == LOAD);
   assign bus.image_input        = img;
   assign bus.convolution_enable = conv_en;
   assign bus.loader_busy        = state == START | state == BUSY;
   assign accept  = bus.pix_valid & bus.pix_ready;
   assign sof_acc = accept & bus.pix_sof;
   assign write   = sof_acc | (accept & state == LOAD & data_beat);
   assign last    = accept & !bus.pix_sof & state == LOAD & beat_cnt == BW'(LAST_CNT);
   // per-bit row/col of this beat; entry PIXELS_PER_BEAT is the next beat's start
   always_comb begin
      base_r = sof_acc ? '0 : row;
      base_c = sof_acc ? '0 : col;
      for (int i = 0; i <= PIXELS_PER_BEAT; i++) begin
         cs[i] = base_c + CW'(i);
         pr[i] = cs[i] >= CW'(IMAGE_WIDTH) ? base_r + RW'(1) : base_r;
         pc[i] = cs[i] >= CW'(IMAGE_WIDTH) ? cs[i] - CW'(IMAGE_WIDTH) : cs[i];
      end
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = sof_acc ? LOAD : IDLE;
`ifdef LOADER_CHECKSUM_EN
         LOAD:    nxt = last ? CHECK : LOAD;
`else
         LOAD:    nxt = last ? START : LOAD;
`endif
         START:   nxt = BUSY;
         BUSY:    nxt = bus.cnn_done ? IDLE : BUSY;
         CHECK:   nxt = csum_ok ? START : IDLE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_cnn)
      if (!rst_cnn) begin
         state    <= IDLE;
         beat_cnt <= '0;
         row      <= '0;
         col      <= '0;
         rdy_en   <= 1'b0;
         conv_en  <= 1'b1;
      end else begin
         state   <= nxt;
         rdy_en  <= 1'b1;
         conv_en <= state != START;
         if (write) begin
            row <= pr[PIXELS_PER_BEAT];
            col <= pc[PIXELS_PER_BEAT];
         end
         if (sof_acc) beat_cnt <= BW'(1);
         else if (accept && state == LOAD) beat_cnt <= beat_cnt + BW'(1);
      end
   always_ff @(posedge clk or negedge rst_cnn)
      if (!rst_cnn) img <= '0;
      else if (write)
         for (int i = 0; i < PIXELS_PER_BEAT; i++)
            img[pr[i][RI-1:0]][pc[i][CI-1:0]] <= bus.pix_data[i];
endmodule

// File: tb/tb_cnn_image_loader.sv
// tb_cnn_image_loader: directed checks of packing, start-pulse timing, back-pressure, sof restart and reset.
// Define LOADER_CHECKSUM_EN for both bench and RTL to exercise the checksum variant.
module tb_cnn_image_loader;
   localparam int NB = 98;
   logic clk, rst_cnn;
   int total = 0, passed = 0, to_cnt = 0;
   logic [7:0] frm [NB];
   cnn_image_loader_if ifc ();
   cnn_image_loader dut (.clk(clk), .rst_cnn(rst_cnn), .bus(ifc.slave));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   task automatic send(input logic [7:0] d, input logic s, input int gap);
      int t = 0;
      ifc.pix_valid = 1'b0;
      repeat (gap) @(negedge clk);
      ifc.pix_data  = d;
      ifc.pix_sof   = s;
      ifc.pix_valid = 1'b1;
      while (!ifc.pix_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) to_cnt++;
      @(negedge clk);
      ifc.pix_valid = 1'b0;
      ifc.pix_sof   = 1'b0;
   endtask
   task automatic send_frame(input int gap);
      logic [7:0] x = 8'h00;
      for (int k = 0; k < NB; k++) begin
         send(frm[k], k == 0, gap);
         x ^= frm[k];
      end
`ifdef LOADER_CHECKSUM_EN
      send(x, 1'b0, gap);
`endif
   endtask
   task automatic chk_pulse(input string t);
`ifdef LOADER_CHECKSUM_EN
      check({t, "_check_rdy"}, ifc.pix_ready, 0);
      @(negedge clk);
`endif
      check({t, "_busy_start"}, ifc.loader_busy, 1);
      check({t, "_en_pre"}, ifc.convolution_enable, 1);
      @(negedge clk);
      check({t, "_en_low"}, ifc.convolution_enable, 0);
      check({t, "_rdy_busy"}, ifc.pix_ready, 0);
      @(negedge clk);
      check({t, "_en_high"}, ifc.convolution_enable, 1);
      check({t, "_busy_hold"}, ifc.loader_busy, 1);
   endtask
   task automatic done(input string t);
      ifc.cnn_done = 1'b1;
      @(negedge clk);
      ifc.cnn_done = 1'b0;
      check({t, "_busy_clr"}, ifc.loader_busy, 0);
      check({t, "_rdy_back"}, ifc.pix_ready, 1);
   endtask
   initial begin
      rst_cnn = 1'b0;
      ifc.pix_data = '0;
      ifc.pix_sof = 1'b0;
      ifc.pix_valid = 1'b0;
      ifc.cnn_done = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_rdy", ifc.pix_ready, 0);
      check("rst_en", ifc.convolution_enable, 1);
      check("rst_busy", ifc.loader_busy, 0);
      check("rst_img", |ifc.image_input, 0);
      check("rst_err", ifc.frame_error, 0);
      rst_cnn = 1'b1;
      check("rel_rdy0", ifc.pix_ready, 0);
      @(negedge clk);
      check("rel_rdy1", ifc.pix_ready, 1);
      // beat without sof in IDLE is acked and dropped
      send(8'hFF, 1'b0, 0);
      check("drop_img", ifc.image_input[0][0], 0);
      check("drop_busy", ifc.loader_busy, 0);
      for (int k = 0; k < NB; k++) frm[k] = 8'hFF;
      send_frame(0);
      chk_pulse("ones");
      check("ones_img", &ifc.image_input, 1);
      done("ones");
      for (int k = 0; k < NB; k++) frm[k] = 8'hAA;
      frm[3] = 8'hF0;
      send_frame(0);
      chk_pulse("chk");
      check("chk_00", ifc.image_input[0][0], 0);
      check("chk_01", ifc.image_input[0][1], 1);
      check("chk_2727", ifc.image_input[27][27], 1);
      check("rowb_r1", ifc.image_input[1][3:0], 4'hF);
      check("rowb_r0", ifc.image_input[0][27:24], 4'h0);
      check("rowb_14", ifc.image_input[1][4], 0);
      check("rowb_15", ifc.image_input[1][5], 1);
      done("chk");
      for (int k = 0; k < NB; k++) frm[k] = 8'h0F;
      send_frame(1);
      chk_pulse("gap");
      // back-pressure while BUSY: image must not change
      ifc.pix_data = 8'h00;
      ifc.pix_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check("bp_rdy", ifc.pix_ready, 0);
         @(negedge clk);
      end
      ifc.pix_valid = 1'b0;
      check("gap_274", ifc.image_input[27][4], 1);
      check("gap_270", ifc.image_input[27][0], 0);
      check("gap_003", ifc.image_input[0][3], 1);
      done("gap");
      send(8'h55, 1'b1, 0);
      for (int k = 1; k < 50; k++) send(8'h55, 1'b0, 0);
      ifc.cnn_done = 1'b1;
      @(negedge clk);
      ifc.cnn_done = 1'b0;
      check("done_load_busy", ifc.loader_busy, 0);
      check("done_load_rdy", ifc.pix_ready, 1);
      send(8'h33, 1'b1, 0);
      for (int k = 1; k < NB-1; k++) send(8'h33, 1'b0, 0);
      check("resof_busy97", ifc.loader_busy, 0);
      @(negedge clk);
      check("resof_en97", ifc.convolution_enable, 1);
      send(8'h33, 1'b0, 0);
`ifdef LOADER_CHECKSUM_EN
      send(8'h00, 1'b0, 0);
`endif
      chk_pulse("resof");
      check("resof_00", ifc.image_input[0][0], 1);
      check("resof_02", ifc.image_input[0][2], 0);
      done("resof");
      for (int k = 0; k < NB; k++) frm[k] = 8'hFF;
      send_frame(0);
      repeat (3) @(negedge clk);
      check("rb_busy", ifc.loader_busy, 1);
      rst_cnn = 1'b0;
      #1;
      check("rb_img", |ifc.image_input, 0);
      check("rb_en", ifc.convolution_enable, 1);
      check("rb_busy0", ifc.loader_busy, 0);
      check("rb_rdy", ifc.pix_ready, 0);
      @(negedge clk);
      rst_cnn = 1'b1;
      @(negedge clk);
      check("rb_rdy1", ifc.pix_ready, 1);
      ifc.cnn_done = 1'b1;
      @(negedge clk);
      ifc.cnn_done = 1'b0;
      @(negedge clk);
      check("rb_done_busy", ifc.loader_busy, 0);
      check("rb_done_en", ifc.convolution_enable, 1);
      check("rb_done_img", |ifc.image_input, 0);
`ifdef LOADER_CHECKSUM_EN
      send(8'h5A, 1'b1, 0);
      for (int k = 1; k < NB; k++) send(8'h00, 1'b0, 0);
      send(8'h00, 1'b0, 0);
      check("bad_check_rdy", ifc.pix_ready, 0);
      @(negedge clk);
      check("bad_err", ifc.frame_error, 1);
      check("bad_busy", ifc.loader_busy, 0);
      check("bad_rdy", ifc.pix_ready, 1);
      check("bad_en0", ifc.convolution_enable, 1);
      @(negedge clk);
      check("bad_en1", ifc.convolution_enable, 1);
      check("bad_err_sticky", ifc.frame_error, 1);
      send(8'h00, 1'b1, 0);
      check("bad_err_clr", ifc.frame_error, 0);
`else
      check("err_tied", ifc.frame_error, 0);
`endif
      check("timeouts", to_cnt, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
